// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared types and constants for the clock-enable divider bank
package clk_div_pkg;

    localparam int DEFAULT_DIV = 3;
    localparam int MAX_WIDTH   = 32;

    typedef enum logic {
        MODE_SQUARE = 1'b0,
        MODE_PULSE  = 1'b1
    } mode_e;

    // div is carried at MAX_WIDTH; the top zero-extends the programmed divisor
    typedef struct packed {
        logic [MAX_WIDTH-1:0] div;
        mode_e                mode;
        logic                 en;
    } chan_cfg_t;

endpackage

// File: rtl/clk_div_chan.sv
// rtl/clk_div_chan.sv - one divider channel: counter, terminal compare, tick and sq output
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int WIDTH   = 12,
    parameter int RST_DIV = DEFAULT_DIV
) (
    input  logic      clk_rx,
    input  logic      rst,
    input  logic      clr,
    input  logic      load,
    input  chan_cfg_t cfg,
    output logic      tick,
    output logic      sq_out
);

    chan_cfg_t            cfg_q;
    logic [WIDTH-1:0]     cnt;
    logic [MAX_WIDTH-1:0] last;
    logic                 terminal;

    // div of 0 behaves like 1; >= keeps a shrunk divisor from running past its end
    always_comb begin
        last     = (cfg_q.div == '0) ? '0 : cfg_q.div - MAX_WIDTH'(1);
        terminal = MAX_WIDTH'(cnt) >= last;
    end

    always_ff @(posedge clk_rx or posedge rst) begin
        if (rst) begin
            cfg_q  <= '{div: MAX_WIDTH'(RST_DIV), mode: MODE_SQUARE, en: 1'b1};
            cnt    <= '0;
            tick   <= 1'b0;
            sq_out <= 1'b0;
        end else begin
            if (load) begin
                cfg_q <= cfg;
            end
            if (load || clr) begin
                cnt    <= '0;
                tick   <= 1'b0;
                sq_out <= 1'b0;
            end else if (cfg_q.en) begin
                if (terminal) begin
                    cnt    <= '0;
                    tick   <= 1'b1;
                    sq_out <= (cfg_q.mode == MODE_PULSE) ? 1'b1 : ~sq_out;
                end else begin
                    cnt  <= cnt + WIDTH'(1);
                    tick <= 1'b0;
                    if (cfg_q.mode == MODE_PULSE) begin
                        sq_out <= 1'b0;
                    end
                end
            end else begin
                tick <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/clk_div_bank.sv
// rtl/clk_div_bank.sv - multi-channel clock-enable divider with config decode and global sync
module clk_div_bank #(
    parameter int CHANNELS    = 4,
    parameter int WIDTH       = 12,
    parameter int DEFAULT_DIV = clk_div_pkg::DEFAULT_DIV,
    parameter int CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk_rx,
    input  logic                rst,
    input  logic                sync,
    input  logic                cfg_we,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [WIDTH-1:0]    cfg_div,
    input  logic                cfg_mode,
    input  logic                cfg_en,
    output logic                cfg_ack,
    output logic                cfg_err,
    output logic [CHANNELS-1:0] tick,
    output logic [CHANNELS-1:0] sq_out
);
    import clk_div_pkg::*;

    chan_cfg_t cfg_in;
    logic      cfg_hit;

    assign cfg_hit = int'(cfg_ch) < CHANNELS;
    assign cfg_in  = '{div: MAX_WIDTH'(cfg_div), mode: mode_e'(cfg_mode), en: cfg_en};

    always_ff @(posedge clk_rx or posedge rst) begin
        if (rst) begin
            cfg_ack <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            cfg_ack <= cfg_we && cfg_hit;
            cfg_err <= cfg_we && !cfg_hit;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        clk_div_chan #(
            .WIDTH   (WIDTH),
            .RST_DIV (DEFAULT_DIV)
        ) u_chan (
            .clk_rx (clk_rx),
            .rst    (rst),
            .clr    (sync),
            .load   (cfg_we && cfg_hit && (int'(cfg_ch) == g)),
            .cfg    (cfg_in),
            .tick   (tick[g]),
            .sq_out (sq_out[g])
        );
    end

endmodule

// File: tb/tb_clk_div_bank.sv
// tb/tb_clk_div_bank.sv - self-checking bench for clk_div_bank (three channels)
module tb_clk_div_bank;

    localparam int NCH = 3;

    logic           clk_rx = 1'b0;
    logic           rst = 1'b1;
    logic           sync = 1'b0;
    logic           cfg_we = 1'b0;
    logic [1:0]     cfg_ch = '0;
    logic [11:0]    cfg_div = '0;
    logic           cfg_mode = 1'b0;
    logic           cfg_en = 1'b1;
    logic           cfg_ack, cfg_err;
    logic [NCH-1:0] tick, sq_out;

    clk_div_bank #(.CHANNELS(NCH), .WIDTH(12), .DEFAULT_DIV(3)) dut (
        .clk_rx   (clk_rx),
        .rst      (rst),
        .sync     (sync),
        .cfg_we   (cfg_we),
        .cfg_ch   (cfg_ch),
        .cfg_div  (cfg_div),
        .cfg_mode (cfg_mode),
        .cfg_en   (cfg_en),
        .cfg_ack  (cfg_ack),
        .cfg_err  (cfg_err),
        .tick     (tick),
        .sq_out   (sq_out)
    );

    always #5 clk_rx = ~clk_rx;

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // reference model: per channel, enabled edges elapsed since the last restart
    int             m_age [NCH];
    int             m_div [NCH];
    logic           m_mode[NCH];
    logic           m_en  [NCH];
    logic [NCH-1:0] m_tick, m_sq;
    logic           m_ack, m_err;

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_age[i] = 0; m_div[i] = 3; m_mode[i] = 1'b0; m_en[i] = 1'b1;
        end
        m_tick = '0; m_sq = '0; m_ack = 1'b0; m_err = 1'b0;
    endtask

    task automatic model_edge();
        logic hit;
        int   dd;
        hit   = cfg_we && (int'(cfg_ch) < NCH);
        m_ack = hit;
        m_err = cfg_we && !hit;
        for (int i = 0; i < NCH; i++) begin
            if (hit && int'(cfg_ch) == i) begin
                m_div[i] = int'(cfg_div); m_mode[i] = cfg_mode; m_en[i] = cfg_en;
            end
            if (sync || (hit && int'(cfg_ch) == i)) begin
                m_age[i] = 0; m_tick[i] = 1'b0; m_sq[i] = 1'b0;
            end else if (m_en[i]) begin
                m_age[i]++;
                dd = (m_div[i] == 0) ? 1 : m_div[i];
                m_tick[i] = (m_age[i] % dd) == 0;
                m_sq[i]   = m_mode[i] ? m_tick[i] : (((m_age[i] / dd) % 2) == 1);
            end else begin
                m_tick[i] = 1'b0;
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk_rx);
        model_edge();
        #1;
        chk("model_tick", tick, m_tick);
        chk("model_sq", sq_out, m_sq);
        chk("model_ack", cfg_ack, m_ack);
        chk("model_err", cfg_err, m_err);
    endtask

    task automatic drive(input logic we, input logic [1:0] ch, input logic [11:0] dv,
                         input logic md, input logic en, input logic sy);
        cfg_we = we; cfg_ch = ch; cfg_div = dv; cfg_mode = md; cfg_en = en; sync = sy;
    endtask

    typedef struct {
        logic       we;
        logic [1:0] ch;
        logic [11:0] dv;
        logic       md;
        logic       sy;
        logic [2:0] e_tick;
        logic [2:0] e_sq;
        logic       e_ack;
        logic       e_err;
    } vec_t;

    vec_t tbl[22];

    function automatic vec_t mk(input logic we, input logic [1:0] ch, input logic [11:0] dv,
                                input logic md, input logic [2:0] t, input logic [2:0] s,
                                input logic a, input logic e);
        vec_t v;
        v.we = we; v.ch = ch; v.dv = dv; v.md = md; v.sy = 1'b0;
        v.e_tick = t; v.e_sq = s; v.e_ack = a; v.e_err = e;
        return v;
    endfunction

    task automatic run_table(input int n);
        for (int i = 0; i < n; i++) begin
            drive(tbl[i].we, tbl[i].ch, tbl[i].dv, tbl[i].md, 1'b1, tbl[i].sy);
            cycle();
            chk($sformatf("tbl%0d_tick", i), tick, tbl[i].e_tick);
            chk($sformatf("tbl%0d_sq", i), sq_out, tbl[i].e_sq);
            chk($sformatf("tbl%0d_ack", i), cfg_ack, tbl[i].e_ack);
            chk($sformatf("tbl%0d_err", i), cfg_err, tbl[i].e_err);
        end
        drive(0, 0, 0, 0, 1, 0);
    endtask

    initial begin
        tbl[0]  = mk(0, 0, 0, 0, 3'b000, 3'b000, 0, 0);
        tbl[1]  = mk(0, 0, 0, 0, 3'b000, 3'b000, 0, 0);
        tbl[2]  = mk(0, 0, 0, 0, 3'b111, 3'b111, 0, 0);
        tbl[3]  = mk(0, 0, 0, 0, 3'b000, 3'b111, 0, 0);
        tbl[4]  = mk(0, 0, 0, 0, 3'b000, 3'b111, 0, 0);
        tbl[5]  = mk(0, 0, 0, 0, 3'b111, 3'b000, 0, 0);
        tbl[6]  = mk(0, 0, 0, 0, 3'b000, 3'b000, 0, 0);
        tbl[7]  = mk(0, 0, 0, 0, 3'b000, 3'b000, 0, 0);
        tbl[8]  = mk(0, 0, 0, 0, 3'b111, 3'b111, 0, 0);
        tbl[9]  = mk(1, 1, 5, 1, 3'b000, 3'b101, 1, 0);
        tbl[10] = mk(0, 0, 0, 0, 3'b000, 3'b101, 0, 0);
        tbl[11] = mk(0, 0, 0, 0, 3'b101, 3'b000, 0, 0);
        tbl[12] = mk(0, 0, 0, 0, 3'b000, 3'b000, 0, 0);
        tbl[13] = mk(0, 0, 0, 0, 3'b000, 3'b000, 0, 0);
        tbl[14] = mk(0, 0, 0, 0, 3'b111, 3'b111, 0, 0);
        tbl[15] = mk(0, 0, 0, 0, 3'b000, 3'b101, 0, 0);
        tbl[16] = mk(0, 0, 0, 0, 3'b000, 3'b101, 0, 0);
        tbl[17] = mk(0, 0, 0, 0, 3'b101, 3'b000, 0, 0);
        tbl[18] = mk(0, 0, 0, 0, 3'b000, 3'b000, 0, 0);
        tbl[19] = mk(0, 0, 0, 0, 3'b010, 3'b010, 0, 0);
        tbl[20] = mk(1, 3, 7, 0, 3'b101, 3'b101, 0, 1);
        tbl[21] = mk(0, 0, 0, 0, 3'b000, 3'b101, 0, 0);

        model_reset();
        #12;
        chk("reset_tick", tick, 3'b000);
        chk("reset_sq", sq_out, 3'b000);
        chk("reset_ack", cfg_ack, 1'b0);
        chk("reset_err", cfg_err, 1'b0);
        rst = 1'b0;
        run_table(22);

        // divisor 0 and 1 both tick every cycle
        for (int v = 0; v < 2; v++) begin
            drive(1, 0, 12'(v), 0, 1, 0);
            cycle();
            drive(0, 0, 0, 0, 1, 0);
            for (int k = 0; k < 4; k++) begin
                cycle();
                chk($sformatf("div%0d_tick0", v), tick[0], 1'b1);
            end
        end

        // shrink divisor 10 -> 2 with the counter at 7
        drive(1, 0, 10, 0, 1, 0);
        cycle();
        drive(0, 0, 0, 0, 1, 0);
        for (int k = 0; k < 7; k++) cycle();
        drive(1, 0, 2, 0, 1, 0);
        cycle();
        drive(0, 0, 0, 0, 1, 0);
        for (int k = 1; k <= 4; k++) begin
            cycle();
            chk($sformatf("shrink_k%0d", k), tick[0], (k % 2) == 0);
        end

        // sync together with a write to ch2: ch0 D=2, ch1 D=5, ch2 D=4 afterwards
        for (int k = 0; k < 3; k++) cycle();
        drive(1, 2, 4, 0, 1, 1);
        cycle();
        chk("sync_ack", cfg_ack, 1'b1);
        chk("sync_tick", tick, 3'b000);
        chk("sync_sq", sq_out, 3'b000);
        drive(0, 0, 0, 0, 1, 0);
        for (int k = 1; k <= 6; k++) begin
            cycle();
            chk($sformatf("sync_k%0d", k), tick, {(k % 4) == 0, (k % 5) == 0, (k % 2) == 0});
        end

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            drive(($urandom % 12) == 0, 2'($urandom % 4),
                  (($urandom % 8) == 0) ? 12'($urandom % 4096) : 12'($urandom % 9),
                  1'($urandom % 2), ($urandom % 6) != 0, ($urandom % 40) == 0);
            cycle();
        end
        drive(0, 0, 0, 0, 1, 0);

        // asynchronous reset between edges, then the reset-release sequence again
        cycle();
        #2;
        rst = 1'b1;
        #1;
        chk("arst_tick", tick, 3'b000);
        chk("arst_sq", sq_out, 3'b000);
        chk("arst_ack", cfg_ack, 1'b0);
        chk("arst_err", cfg_err, 1'b0);
        model_reset();
        #2;
        rst = 1'b0;
        run_table(9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
